div8_seq: RTL and testbench
===========================

Name: div8_seq

Overview:
- Sequential 8-bit unsigned restoring divider. It sits directly downstream of the 8-bit ripple-borrow subtractor and consumes its dif/bor outputs.
- Instantiates one fsb8 and reuses it once per clock, retiring one quotient bit per cycle.
- Provides a start/busy/done handshake so a controller can launch a division and collect the quotient and remainder.

Parameters:
- none. Width is fixed at 8 to match fsb8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  8  unsigned dividend; latched when start is accepted
- divisor  input  8  unsigned divisor; latched when start is accepted
- busy  output  1  high while an accepted division is in progress
- done  output  1  one-cycle pulse when results are valid
- quotient  output  8  unsigned quotient; held until the next accepted start
- remainder  output  8  unsigned remainder; held until the next accepted start
- div_by_zero  output  1  set with done if the latched divisor was 0; held with the results

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal R, Q, D and cnt all 0.
- State IDLE:
  - If start=1 at a clock edge: load Q<=dividend, D<=divisor, R<=0, cnt<=0; go to RUN; busy<=1.
  - start=0: remain in IDLE; outputs hold.
- State RUN, one iteration per edge:
  - Form S = {R[6:0], Q[7]}.
  - Apply fsb8 with a=S, b=D.
  - If bor[0]=0: R<=dif and the new Q LSB is 1. Otherwise R<=S and the new Q LSB is 0.
  - Q<={Q[6:0], new LSB}; cnt<=cnt+1.
  - On the 8th iteration (cnt=7): go to DONE. Register quotient<=new Q, remainder<=new R, div_by_zero<=(D==0); busy<=0, done<=1.
- State DONE: lasts exactly one cycle. done<=0, then go to IDLE. start is ignored in DONE.
- Latency: start sampled at edge E0 → busy high after E0 → done high for the single cycle after E8, with results valid in that same cycle. Back-to-back issue: next start is accepted earliest at E10.
- Width invariant: the shifted partial remainder S never exceeds 8 bits, because R after k steps is < 2^k and < D. No 9th bit is kept. The bench asserts R < 128 at the start of the 8th iteration.
- Divide by zero needs no special datapath. The subtractor always succeeds, giving quotient=8'hFF, remainder=dividend, div_by_zero=1. Latency is the normal 8 cycles.
- start while busy (RUN or DONE): ignored. The in-flight operation and its latched operands are unaffected. Changes on dividend/divisor after acceptance have no effect.
- Reset mid-operation: asynchronous return to IDLE. All outputs go to 0 immediately. No done pulse is produced for the aborted operation.
- Outputs quotient, remainder and div_by_zero change only at the DONE transition or on reset. They are not cleared by a new start.

Test Plan:
- Reset then start with 200/7 → busy for 8 cycles; done pulses once 8 cycles after the start edge; quotient=28 (0x1C), remainder=4, div_by_zero=0.
- Boundaries: 255/1 → Q=255, R=0. 5/9 → Q=0, R=5. 255/255 → Q=1, R=0. 0/13 → Q=0, R=0. Each has the same 8-cycle latency.
- 0xAB/0 → Q=0xFF, R=0xAB, div_by_zero=1. A following 10/3 → Q=3, R=1, div_by_zero=0.
- Start 100/9, then pulse start with 50/5 and toggle the operand inputs during RUN → the second request is ignored; results are Q=11, R=1. A start in the cycle after done → accepted normally.
- Assert rst asynchronously mid-cycle at iteration 4 of 77/6 → busy, done and all outputs go to 0 immediately without waiting for clk. No done pulse follows. A fresh 77/6 afterwards gives Q=12, R=5.
- Random sweep of 2000 operand pairs (divisor≠0) vs. a behavioural model → quotient*divisor + remainder == dividend and remainder < divisor on every done pulse.

Source files
------------

// File: rtl/div8_seq_if.sv
// Controller-facing port bundle of the sequential divider.
// Handshake: start is sampled only while busy=0 and done=0 (IDLE); the cycle after
// acceptance busy rises, and done pulses for one cycle with quotient/remainder valid.
interface div8_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/fsb8.sv
// 8-bit ripple-borrow subtractor: dif = a - b, bor = borrow out of the MSB.
module fsb8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] dif,
  output logic [0:0] bor
);
  logic [8:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign dif[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end

  assign bor = c[8];
endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock,
// reusing a single fsb8 for the trial subtraction.
module div8_seq (
  input  logic      clk,
  input  logic      rst,
  div8_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  logic [7:0] r, q, d;
  logic [2:0] cnt;
  logic       busy_r, done_r, dz_r;
  logic [7:0] quot_r, rem_r;

  logic [7:0] s, dif, new_r, new_q;
  logic [0:0] bor;

  // R stays below 128 before the last step, so the shifted value fits in 8 bits.
  assign s = {r[6:0], q[7]};

  fsb8 u_sub (
    .a   (s),
    .b   (d),
    .dif (dif),
    .bor (bor)
  );

  assign new_r = bor[0] ? s : dif;
  assign new_q = {q[6:0], ~bor[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      r      <= 8'd0;
      q      <= 8'd0;
      d      <= 8'd0;
      cnt    <= 3'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= 8'd0;
      rem_r  <= 8'd0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            q      <= bus.dividend;
            d      <= bus.divisor;
            r      <= 8'd0;
            cnt    <= 3'd0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          r   <= new_r;
          q   <= new_q;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quot_r <= new_q;
            rem_r  <= new_r;
            dz_r   <= (d == 8'd0);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_div8_seq.sv
// Bench for div8_seq: timeline model of busy/done/results plus a result scoreboard,
// directed boundary cases, abort-by-reset and a random operand sweep.
module tb_div8_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  div8_seq_if bus ();

  div8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [16:0] exp_q[$];
  logic [16:0] sb_e;
  bit          active  = 1'b0;
  int          ec      = 0;
  int          e0      = 0;
  logic [16:0] pend    = 17'd0;
  logic [16:0] held    = 17'd0;

  function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    return {1'b0, a / b, a % b};
  endfunction

  // Operation accepted at edge e0: busy after e0..e0+7, done after e0+8, idle from e0+10.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      held   <= 17'd0;
      exp_q.delete();
    end else begin
      ec <= ec + 1;
      if (active && (ec + 1 - e0 == 8)) held <= pend;
      if (bus.start && (!active || (ec + 1 - e0 >= 10))) begin
        active <= 1'b1;
        e0     <= ec + 1;
        pend   <= ref_div(bus.dividend, bus.divisor);
        exp_q.push_back(ref_div(bus.dividend, bus.divisor));
      end
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, bus.busy}, {31'd0, active && (ec - e0 <= 7)});
      check("done", {31'd0, bus.done}, {31'd0, active && (ec - e0 == 8)});
      check("quotient", {24'd0, bus.quotient}, {24'd0, held[15:8]});
      check("remainder", {24'd0, bus.remainder}, {24'd0, held[7:0]});
      check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, held[16]});
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard: done with nothing expected at %0t", $time);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_result", {15'd0, bus.div_by_zero, bus.quotient, bus.remainder}, {15'd0, sb_e});
        end
      end
      if (bus.busy && dut.cnt == 3'd7)
        check("r_width", {31'd0, dut.r < 8'd128}, 32'd1);
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int n;
    issue(a, b);
    wait_done(n);
    check("latency", n, 32'd8);
    check("lit_q", {24'd0, bus.quotient}, {24'd0, eq});
    check("lit_r", {24'd0, bus.remainder}, {24'd0, er});
    check("lit_dz", {31'd0, bus.div_by_zero}, {31'd0, edz});
  endtask

  int n;
  int ra, rb, rq, rr;

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_q", {24'd0, bus.quotient}, 32'd0);
    check("rst_r", {24'd0, bus.remainder}, 32'd0);
    check("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_op(8'd0, 8'd13, 8'd0, 8'd0, 1'b0);
    run_op(8'hAB, 8'd0, 8'hFF, 8'hAB, 1'b1);
    run_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

    // Start requests and operand changes during RUN must be ignored.
    issue(8'd100, 8'd9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start    = (i % 2 == 0);
      bus.dividend = 8'd50 + 8'(i);
      bus.divisor  = 8'd5 ^ 8'(i);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'(ra + 17);
    wait_done(n);
    check("ign_done_seen", {31'd0, bus.done}, 32'd1);
    check("ign_q", {24'd0, bus.quotient}, 32'd11);
    check("ign_r", {24'd0, bus.remainder}, 32'd1);

    // A start held during the DONE cycle is ignored.
    bus.start    = 1'b1;
    bus.dividend = 8'd1;
    bus.divisor  = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_ign_busy", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset part-way through 77/6.
    issue(8'd77, 8'd6);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_q", {24'd0, bus.quotient}, 32'd0);
    check("abort_r", {24'd0, bus.remainder}, 32'd0);
    check("abort_dz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(8'd77, 8'd6, 8'd12, 8'd5, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(1, 255);
      issue(8'(ra), 8'(rb));
      wait_done(n);
      check("rand_lat", n, 32'd8);
      rq = int'(bus.quotient);
      rr = int'(bus.remainder);
      check("rand_identity", rq * rb + rr, ra);
      check("rand_rem_lt", {31'd0, rr < rb}, 32'd1);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
